// File: rtl/serializer_pkg.sv
// Shared types and constants for the RPi status serializer.
// Build option: define SERIALIZER_PARITY_EN to append one even-parity bit
// after the status words of every frame.
package serializer_pkg;

  // sdo level once a non-wrapping frame has been fully shifted out
  localparam bit          IDLE_LEVEL_DEFAULT = 1'b0;

  // Fewest synchroniser flops accepted for an asynchronous RPi pin
  localparam int unsigned MIN_SYNC_STAGES    = 2;

`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Frame controller states
  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,  // no live frame (after reset or after exhaustion)
    SER_LATCH = 2'd1,  // RPi holds latch, snapshot tracks data_in
    SER_SHIFT = 2'd2   // frame live, sclk rising edges advance the index
  } ser_state_e;

  // Bits per frame, including the optional parity bit
  function automatic int unsigned total_bits(input int unsigned word_w,
                                             input int unsigned num_words);
    return word_w * num_words + PARITY_BITS;
  endfunction

  // Index width able to hold 0..total inclusive
  function automatic int unsigned index_width(input int unsigned total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser for one asynchronous input plus rising-edge detect.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   async_i    : asynchronous input pin
//   level_o    : synchronised level (last synchroniser flop)
//   rise_c     : combinational one-cycle pulse on a synchronised 0->1 edge
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift chain and one-cycle-delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_c  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/rpi_status_serializer.sv
// Serial status link from FPGA to Raspberry Pi. While the RPi holds latch
// high the status vector is snapshotted every cycle; after latch release
// each RPi sclk rising edge advances one bit, presented on sdo.
// Build option: SERIALIZER_PARITY_EN appends an even-parity bit over the
// snapshot, computed when the snapshot is taken.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   data_in     : status words, word k = data_in[k*WORD_W +: WORD_W]
//   latch_async : RPi frame latch (level, asynchronous)
//   sclk_async  : RPi shift clock (asynchronous, rising edge advances)
//   sdo         : serial data to RPi (registered)
//   bit_index   : current bit position, holds TOTAL once exhausted
//   frame_done  : one-cycle pulse when the last bit is consumed
//   active      : high from latch release until the frame is exhausted
module rpi_status_serializer
  import serializer_pkg::*;
#(
  parameter  int unsigned WORD_W      = 16,
  parameter  int unsigned NUM_WORDS   = 1,
  parameter  bit          LSB_FIRST   = 1'b1,
  parameter  bit          WRAP        = 1'b0,
  parameter  bit          IDLE_LEVEL  = IDLE_LEVEL_DEFAULT,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned DATA_BITS   = WORD_W * NUM_WORDS,
  localparam int unsigned TOTAL       = total_bits(WORD_W, NUM_WORDS),
  localparam int unsigned IDX_W       = index_width(TOTAL)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 latch_async,
  input  logic                 sclk_async,
  output logic                 sdo,
  output logic [IDX_W-1:0]     bit_index,
  output logic                 frame_done,
  output logic                 active
);

  localparam int unsigned STAGES =
    (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic latch_s;
  logic sclk_rise;
  logic unused_latch_rise;
  logic unused_sclk_level;

  ser_state_e state_q, state_d;

  logic [DATA_BITS-1:0] snap_q, snap_d;
  logic [DATA_BITS-1:0] frame_bits;
  logic [IDX_W-1:0]     bit_index_q, bit_index_d;
  logic                 frame_done_q, frame_done_d;
  logic                 active_q, active_d;
  logic                 sdo_q, sdo_d;
  logic                 last_bit;
  logic                 shift_step;

  // Asynchronous RPi pins into the clk domain
  sync_edge_detect #(.STAGES(STAGES)) u_latch_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (latch_async),
    .level_o (latch_s),
    .rise_c  (unused_latch_rise)
  );

  sync_edge_detect #(.STAGES(STAGES)) u_sclk_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (sclk_async),
    .level_o (unused_sclk_level),
    .rise_c  (sclk_rise)
  );

  assign last_bit = (bit_index_q == IDX_W'(TOTAL - 1));

  // Frame controller state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SER_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame controller next state; latch overrides everything, including
  // an sclk edge seen on the same cycle
  always_comb begin
    state_d = state_q;
    if (latch_s) begin
      state_d = SER_LATCH;
    end else begin
      case (state_q)
        SER_LATCH: state_d = SER_SHIFT;
        SER_SHIFT: begin
          if (sclk_rise && last_bit && !WRAP) begin
            state_d = SER_IDLE;
          end
        end
        default:   state_d = state_q;
      endcase
    end
  end

  // Frame controller outputs: datapath next values
  always_comb begin
    snap_d       = snap_q;
    bit_index_d  = bit_index_q;
    shift_step   = 1'b0;
    frame_done_d = 1'b0;
    active_d     = (state_d == SER_SHIFT);
    if (latch_s) begin
      snap_d      = data_in;
      bit_index_d = '0;
    end else if (state_q == SER_SHIFT && sclk_rise) begin
      shift_step   = 1'b1;
      frame_done_d = last_bit;
      if (last_bit && WRAP) begin
        bit_index_d = '0;
      end else begin
        bit_index_d = bit_index_q + IDX_W'(1);
      end
    end
  end

  // Snapshot reordered into transmit order: word 0 first, bit order per word
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    for (genvar j = 0; j < WORD_W; j++) begin : g_bit
      if (LSB_FIRST) begin : g_lsb
        assign frame_bits[w*WORD_W + j] = snap_q[w*WORD_W + j];
      end else begin : g_msb
        assign frame_bits[w*WORD_W + j] = snap_q[w*WORD_W + (WORD_W - 1 - j)];
      end
    end
  end

`ifdef SERIALIZER_PARITY_EN
  logic parity_q, parity_d;

  // Parity follows the snapshot so it always describes the frozen frame
  assign parity_d = latch_s ? (^data_in) : parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // Bit selection for the current index; out-of-frame positions idle
  always_comb begin
    sdo_d = IDLE_LEVEL;
    for (int unsigned i = 0; i < DATA_BITS; i++) begin
      if (bit_index_q == IDX_W'(i)) begin
        sdo_d = frame_bits[i];
      end
    end
`ifdef SERIALIZER_PARITY_EN
    if (last_bit) begin
      sdo_d = parity_q;
    end
`endif
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q       <= '0;
      bit_index_q  <= '0;
      frame_done_q <= 1'b0;
      active_q     <= 1'b0;
      sdo_q        <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      bit_index_q  <= bit_index_d;
      frame_done_q <= frame_done_d;
      active_q     <= active_d;
      sdo_q        <= sdo_d;
    end
  end

  assign sdo        = sdo_q;
  assign bit_index  = bit_index_q;
  assign frame_done = frame_done_q;
  assign active     = active_q;

endmodule

// File: tb/tb_rpi_status_serializer.sv
// Bench for rpi_status_serializer: three configurations driven from one
// latch/sclk pair and compared against a frame-level reference model.
//   cfg 0: WORD_W=16, NUM_WORDS=1, LSB first, no wrap
//   cfg 1: WORD_W=16, NUM_WORDS=2, MSB first, no wrap
//   cfg 2: WORD_W=16, NUM_WORDS=1, LSB first, wrap
module tb_rpi_status_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int T0  = 16 + PAR;
  localparam int T1  = 32 + PAR;
  localparam int T2  = 16 + PAR;
  localparam int IW0 = $clog2(T0 + 1);
  localparam int IW1 = $clog2(T1 + 1);
  localparam int IW2 = $clog2(T2 + 1);

  logic clk = 1'b0;
  logic reset;
  logic latch_async;
  logic sclk_async;
  logic [15:0] d0;
  logic [31:0] d1;
  logic [15:0] d2;
  logic [2:0]  sdo_v;
  logic [2:0]  fd_v;
  logic [2:0]  act_v;
  logic [IW0-1:0] idx0;
  logic [IW1-1:0] idx1;
  logic [IW2-1:0] idx2;

  always #5 clk = ~clk;

  rpi_status_serializer #(
    .WORD_W(16), .NUM_WORDS(1), .LSB_FIRST(1'b1), .WRAP(1'b0),
    .IDLE_LEVEL(1'b0), .SYNC_STAGES(2)
  ) u_dut_lsb (
    .clk(clk), .reset(reset), .data_in(d0), .latch_async(latch_async),
    .sclk_async(sclk_async), .sdo(sdo_v[0]), .bit_index(idx0),
    .frame_done(fd_v[0]), .active(act_v[0])
  );

  rpi_status_serializer #(
    .WORD_W(16), .NUM_WORDS(2), .LSB_FIRST(1'b0), .WRAP(1'b0),
    .IDLE_LEVEL(1'b0), .SYNC_STAGES(2)
  ) u_dut_msb2 (
    .clk(clk), .reset(reset), .data_in(d1), .latch_async(latch_async),
    .sclk_async(sclk_async), .sdo(sdo_v[1]), .bit_index(idx1),
    .frame_done(fd_v[1]), .active(act_v[1])
  );

  rpi_status_serializer #(
    .WORD_W(16), .NUM_WORDS(1), .LSB_FIRST(1'b1), .WRAP(1'b1),
    .IDLE_LEVEL(1'b0), .SYNC_STAGES(2)
  ) u_dut_wrap (
    .clk(clk), .reset(reset), .data_in(d2), .latch_async(latch_async),
    .sclk_async(sclk_async), .sdo(sdo_v[2]), .bit_index(idx2),
    .frame_done(fd_v[2]), .active(act_v[2])
  );

  // frame_done high-cycle counters, sampled away from the active edge
  int fd_cnt0 = 0;
  int fd_cnt1 = 0;
  int fd_cnt2 = 0;
  always @(negedge clk) begin
    if (fd_v[0]) fd_cnt0 <= fd_cnt0 + 1;
    if (fd_v[1]) fd_cnt1 <= fd_cnt1 + 1;
    if (fd_v[2]) fd_cnt2 <= fd_cnt2 + 1;
  end

  // Reference model state
  int          n_tests  = 0;
  int          n_failed = 0;
  bit          armed;      // a latch has been released since reset
  int          n;          // sclk edges since latch release
  logic [31:0] snap_m [3];
  int          fd_base [3];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int total_of(input int c);
    return ((c == 1) ? 32 : 16) + PAR;
  endfunction

  // Transmit-order bit pos of a frame built from snapshot s
  function automatic logic model_bit(input int c, input logic [31:0] s,
                                     input int pos);
    int   nbits;
    int   w;
    int   j;
    int   b;
    logic p;
    nbits = (c == 1) ? 32 : 16;
    if (pos < nbits) begin
      w = pos / 16;
      j = pos % 16;
      b = (c == 1) ? (15 - j) : j;
      return s[5'(w * 16 + b)];
    end
    if (PAR == 1 && pos == nbits) begin
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p = p ^ s[5'(i)];
      return p;
    end
    return 1'b0;
  endfunction

  function automatic int exp_pos(input int c);
    if (!armed) return 0;
    if (c == 2) return n % total_of(c);
    return (n < total_of(c)) ? n : total_of(c);
  endfunction

  function automatic int exp_act(input int c);
    if (!armed) return 0;
    return (c == 2 || n < total_of(c)) ? 1 : 0;
  endfunction

  function automatic int exp_fd(input int c);
    if (!armed) return 0;
    if (c == 2) return n / total_of(c);
    return (n >= total_of(c)) ? 1 : 0;
  endfunction

  function automatic int idx_of(input int c);
    if (c == 0) return 32'(idx0);
    if (c == 1) return 32'(idx1);
    return 32'(idx2);
  endfunction

  function automatic int fd_of(input int c);
    if (c == 0) return fd_cnt0;
    if (c == 1) return fd_cnt1;
    return fd_cnt2;
  endfunction

  task automatic check_all(input string tag);
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("%s.idx%0d", tag, c), 32'(idx_of(c)), 32'(exp_pos(c)));
      check_eq($sformatf("%s.sdo%0d", tag, c), 32'(sdo_v[2'(c)]),
               32'(model_bit(c, snap_m[c], exp_pos(c))));
      check_eq($sformatf("%s.act%0d", tag, c), 32'(act_v[2'(c)]), 32'(exp_act(c)));
      check_eq($sformatf("%s.fd%0d", tag, c), 32'(fd_of(c) - fd_base[c]),
               32'(exp_fd(c)));
    end
  endtask

  task automatic sclk_edge(input string tag);
    sclk_async = 1'b1;
    repeat (6) @(negedge clk);
    if (armed) n++;
    check_all(tag);
    sclk_async = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Latch a new frame; an sclk pulse during latch must be ignored and an
  // aborted frame must not pulse frame_done
  task automatic do_latch(input logic [15:0] a, input logic [31:0] b,
                          input logic [15:0] c2, input string tag);
    d0 = a; d1 = b; d2 = c2;
    latch_async = 1'b1;
    repeat (8) @(negedge clk);
    sclk_async = 1'b1;
    repeat (6) @(negedge clk);
    sclk_async = 1'b0;
    repeat (6) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("%s.lidx%0d", tag, c), 32'(idx_of(c)), 32'd0);
      check_eq($sformatf("%s.lact%0d", tag, c), 32'(act_v[2'(c)]), 32'd0);
      check_eq($sformatf("%s.lfd%0d", tag, c), 32'(fd_of(c) - fd_base[c]),
               32'(exp_fd(c)));
    end
    latch_async = 1'b0;
    repeat (8) @(negedge clk);
    armed = 1'b1;
    n = 0;
    snap_m[0] = {16'h0, a};
    snap_m[1] = b;
    snap_m[2] = {16'h0, c2};
    fd_base[0] = fd_cnt0; fd_base[1] = fd_cnt1; fd_base[2] = fd_cnt2;
    // Snapshot must stay frozen while data_in moves on
    d0 = 16'($urandom); d1 = $urandom; d2 = 16'($urandom);
    check_all({tag, ".rel"});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq({tag, ".sdo"}, 32'(sdo_v), 32'd0);
    check_eq({tag, ".act"}, 32'(act_v), 32'd0);
    check_eq({tag, ".fd"},  32'(fd_v),  32'd0);
    check_eq({tag, ".idx0"}, 32'(idx0), 32'd0);
    check_eq({tag, ".idx1"}, 32'(idx1), 32'd0);
    check_eq({tag, ".idx2"}, 32'(idx2), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) snap_m[c] = 32'h0;
    repeat (2) @(negedge clk);
    fd_base[0] = fd_cnt0; fd_base[1] = fd_cnt1; fd_base[2] = fd_cnt2;
  endtask

  initial begin
    reset = 1'b1;
    latch_async = 1'b0;
    sclk_async = 1'b0;
    d0 = 16'h0; d1 = 32'h0; d2 = 16'h0;
    armed = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      snap_m[c] = 32'h0;
      fd_base[c] = 0;
    end

    do_reset("rst0");
    check_all("pre");
    sclk_edge("prelatch");
    sclk_edge("prelatch");

    // Directed frames: A5C3 LSB first, two-word MSB first, wrap on 0003
    do_latch(16'hA5C3, {16'h0001, 16'h8000}, 16'h0003, "dir");
    for (int e = 1; e <= 34; e++) sclk_edge($sformatf("dir.e%0d", e));

    // Mid-frame re-latch with all ones
    do_latch(16'h1234, 32'h89AB_CDEF, 16'h5A5A, "ab");
    for (int e = 1; e <= 5; e++) sclk_edge($sformatf("ab.e%0d", e));
    do_latch(16'hFFFF, 32'hFFFF_FFFF, 16'hFFFF, "relatch");
    for (int e = 1; e <= 17; e++) sclk_edge($sformatf("ones.e%0d", e));

    // Parity-visible frame, then reset mid-frame after 7 edges
    do_latch(16'h0001, 32'h0000_0001, 16'h0001, "par");
    for (int e = 1; e <= 7; e++) sclk_edge($sformatf("par.e%0d", e));
    do_reset("rstmid");
    for (int e = 1; e <= 3; e++) sclk_edge($sformatf("postrst.e%0d", e));

    // Randomised frames of random length, occasional resets
    for (int f = 0; f < 8; f++) begin
      int edges;
      do_latch(16'($urandom), $urandom, 16'($urandom), $sformatf("rnd%0d", f));
      edges = int'($urandom_range(0, 40));
      for (int e = 1; e <= edges; e++) sclk_edge($sformatf("rnd%0d.e%0d", f, e));
      if ($urandom_range(0, 4) == 0) do_reset($sformatf("rnd%0d.rst", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/rpi_status_serializer.md
# rpi_status_serializer

Parametrised serial status link from FPGA to Raspberry Pi. Snapshots a multi-word status vector (GBA keys and extra status words) and shifts it out one bit per RPi-driven shift clock over a single GPIO. RPi latch and shift-clock pins are treated as asynchronous and sampled in the system clock domain. Sits in the top level between the GBA cartridge interface (status producer) and the RPi GPIO pins.

## Interface
Parameters:
- WORD_W, 16, bits per status word
- NUM_WORDS, 1, number of words in data_in
- LSB_FIRST, 1, 1 = each word shifted LSB first, 0 = MSB first
- WRAP, 0, 1 = bit index wraps to 0 after the last bit; 0 = stop and drive IDLE_LEVEL
- IDLE_LEVEL, 0, sdo level after the frame has been exhausted (WRAP=0)
- SYNC_STAGES, 2, synchroniser flops per async input (>=2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- data_in  in  NUM_WORDS*WORD_W  status vector; word k = data_in[k*WORD_W +: WORD_W]
- latch_async  in  1  RPi frame latch, level-active high, asynchronous
- sclk_async  in  1  RPi shift clock, asynchronous; rising edge advances one bit
- sdo  out  1  serial data to RPi
- bit_index  out  $clog2(TOTAL+1)  current bit position
- frame_done  out  1  one-cycle pulse when the last bit has been consumed
- active  out  1  high from latch release until frame exhausted

## Operation
- TOTAL = NUM_WORDS*WORD_W, plus 1 when parity is enabled.
- latch_s, sclk_s = synchronised inputs; sclk_rise = sclk_s & ~sclk_s_d.
- Latch phase (latch_s=1): snapshot <= data_in every cycle; bit_index <= 0; active <= 0. sclk_rise is ignored. The snapshot freezes on the cycle latch_s falls; active <= 1 on that cycle.
- Shift phase (latch_s=0, active=1): each sclk_rise increments bit_index.
  - On the increment to TOTAL (WRAP=0): frame_done pulses, active <= 0, bit_index holds at TOTAL. Further sclk_rise is ignored.
  - On the increment to TOTAL (WRAP=1): bit_index <= 0, frame_done pulses, and active stays 1. The same snapshot is replayed.
- sdo selection (registered):
  - Word order is always word 0 first.
  - Within a word, bit j = LSB_FIRST ? j : WORD_W-1-j.
  - Index TOTAL-1 is the parity bit when parity is enabled.
  - Index TOTAL drives IDLE_LEVEL.
- Before the first latch after reset, active=0 and sclk_rise is ignored.
- Latch asserted mid-frame aborts the frame at once: bit_index = 0 and no frame_done pulse.
- Simultaneous latch_s=1 and sclk_rise: latch wins.

## Timing
- Reset values: sdo=0, bit_index=0, frame_done=0, active=0, snapshot=0. Synchroniser flops clear to 0.
- Input latency: an async edge is seen as latch_s or sclk_rise SYNC_STAGES+1 clk cycles later.
- sdo is valid 1 cycle after the bit_index or snapshot update, so sdo lags the async sclk edge by SYNC_STAGES+2 cycles.
- RPi requirement: hold each sclk/latch level for at least SYNC_STAGES+2 clk periods, and sample sdo no earlier than SYNC_STAGES+3 clk periods after the sclk rising edge. Shorter pulses may be lost; this is not detected.
- frame_done asserts on the cycle bit_index updates to TOTAL (or wraps to 0).

## Configuration
- SERIALIZER_PARITY_EN defined:
  - TOTAL includes one trailing bit.
  - That bit is even parity (XOR) over the full snapshot, computed at snapshot time.
- SERIALIZER_PARITY_EN undefined:
  - TOTAL = NUM_WORDS*WORD_W.
  - No parity logic is present.

## Structure
- Package serializer_pkg: function for TOTAL and index width; constants for the IDLE_LEVEL default and the minimum SYNC_STAGES.
- Sub-module sync_edge_detect (parameter STAGES): synchroniser plus rising edge detect. Instantiated twice, for latch and sclk.

## Test plan
- WORD_W=16, NUM_WORDS=1, LSB_FIRST=1, data_in=16'hA5C3; latch then 16 sclk edges:
  - sdo = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - frame_done pulses once after edge 16.
  - A 17th edge leaves sdo=IDLE_LEVEL.
- LSB_FIRST=0, NUM_WORDS=2, data_in={16'h0001,16'h8000}; 32 edges:
  - sdo = 1, then 30 zeros, then 1.
  - active drops with frame_done.
- WRAP=1, data_in=16'h0003; 20 edges:
  - sdo pattern restarts 1,1,0,0 at edges 16..19.
  - frame_done pulses at edge 16 only.
- Mid-frame re-latch: after 5 edges, assert latch with data_in=16'hFFFF. Expect:
  - bit_index=0 and no frame_done.
  - The next 16 edges all give sdo=1.
- Reset mid-frame after 7 edges: next cycle all outputs are at reset values, and sclk edges are ignored until the next latch.
- SERIALIZER_PARITY_EN, data_in=16'h0001:
  - Bit 16 = 1; frame_done pulses after edge 17.
  - With data_in=16'hA5C3, bit 16 = 0.
